// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the CP0-lite exception sequencer:
// cause codes, FSM encodings and MFC0 selects.
package exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FLUSH   = 3'd1;
  localparam logic [2:0] ST_VECTOR  = 3'd2;
  localparam logic [2:0] ST_HANDLER = 3'd3;
  localparam logic [2:0] ST_RETURN  = 3'd4;

  localparam logic [1:0] SEL_STATUS = 2'd0;
  localparam logic [1:0] SEL_CAUSE  = 2'd1;
  localparam logic [1:0] SEL_EPC    = 2'd2;
  localparam logic [1:0] SEL_BADV   = 2'd3;

  function automatic logic [31:0] cause_word(
    input logic [4:0] code
  );
    return {25'd0, code, 2'b00};
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder from exception requests to {take, code}.
// Order: ill > address error > ovf > sys > irq.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic       ill,
  input  logic       adel,
  input  logic       ovf,
  input  logic       sys,
  input  logic       irq,
  output logic       take,
  output logic [4:0] code
);

  always_comb begin
    take = 1'b1;
    code = EXC_INT;
    priority case (1'b1)
      ill:     code = EXC_RI;
      adel:    code = EXC_ADEL;
      ovf:     code = EXC_OV;
      sys:     code = EXC_SYS;
      irq:     code = EXC_INT;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/exc_ctrl.sv
// CP0-lite exception/interrupt sequencer: captures EPC/CAUSE/STATUS,
// flushes, vectors, and returns on ERET. Option: EXC_BADADDR_EN.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR = 32'h0000_0180,
  parameter logic        RESET_IE    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] cur_pc,
  input  logic        exc_ill,
  input  logic        exc_ovf,
  input  logic        exc_sys,
  input  logic        irq,
  input  logic        eret,
`ifdef EXC_BADADDR_EN
  input  logic        exc_addr_err,
  input  logic [31:0] bad_addr,
`endif
  input  logic [1:0]  mfc0_sel,
  output logic [31:0] mfc0_data,
  output logic        stall,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        in_handler
);

  logic [2:0]  state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic        ie_q, ie_d;
  logic        df_q, df_d;
  logic        in_handler_q, in_handler_d;
`ifdef EXC_BADADDR_EN
  logic [31:0] badv_q, badv_d;
`endif

  logic       adel_req;
  logic       irq_req;
  logic       take;
  logic [4:0] code;

`ifdef EXC_BADADDR_EN
  assign adel_req = instr_valid & exc_addr_err;
`else
  assign adel_req = 1'b0;
`endif

  // Interrupts are only taken from IDLE; in the handler IE is 0 anyway.
  assign irq_req = instr_valid & irq & ie_q
                 & (state_q == ST_IDLE);

  exc_prio_enc u_prio (
    .ill  (instr_valid & exc_ill),
    .adel (adel_req),
    .ovf  (instr_valid & exc_ovf),
    .sys  (instr_valid & exc_sys),
    .irq  (irq_req),
    .take (take),
    .code (code)
  );

  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    ie_d         = ie_q;
    df_d         = df_q;
    in_handler_d = in_handler_q;
`ifdef EXC_BADADDR_EN
    badv_d       = badv_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = ST_FLUSH;
          cause_d = cause_word(code);
          epc_d   = (code == EXC_INT) ? cur_pc + 32'd4
                                      : cur_pc;
`ifdef EXC_BADADDR_EN
          badv_d  = bad_addr;
`endif
        end
      end
      ST_FLUSH: begin
        ie_d    = 1'b0;
        state_d = ST_VECTOR;
      end
      ST_VECTOR: begin
        in_handler_d = 1'b1;
        state_d      = ST_HANDLER;
      end
      ST_HANDLER: begin
        // A fault inside the handler beats a same-cycle ERET.
        if (take) begin
          df_d    = 1'b1;
          cause_d = cause_word(code);
          state_d = ST_FLUSH;
`ifdef EXC_BADADDR_EN
          badv_d  = bad_addr;
`endif
        end else if (instr_valid & eret) begin
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        ie_d         = 1'b1;
        in_handler_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      epc_q        <= 32'd0;
      cause_q      <= 32'd0;
      ie_q         <= RESET_IE;
      df_q         <= 1'b0;
      in_handler_q <= 1'b0;
`ifdef EXC_BADADDR_EN
      badv_q       <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      ie_q         <= ie_d;
      df_q         <= df_d;
      in_handler_q <= in_handler_d;
`ifdef EXC_BADADDR_EN
      badv_q       <= badv_d;
`endif
    end
  end

  assign stall      = (state_q == ST_FLUSH);
  assign flush      = (state_q == ST_FLUSH);
  assign redirect   = (state_q == ST_VECTOR)
                    | (state_q == ST_RETURN);
  assign in_handler = in_handler_q;

  always_comb begin
    redirect_pc = 32'd0;
    if (state_q == ST_VECTOR) redirect_pc = VECTOR_ADDR;
    if (state_q == ST_RETURN) redirect_pc = epc_q;
  end

  always_comb begin
    mfc0_data = 32'd0;
    unique case (mfc0_sel)
      SEL_STATUS: mfc0_data = {30'd0, df_q, ie_q};
      SEL_CAUSE:  mfc0_data = cause_q;
      SEL_EPC:    mfc0_data = epc_q;
`ifdef EXC_BADADDR_EN
      SEL_BADV:   mfc0_data = badv_q;
`else
      SEL_BADV:   mfc0_data = 32'd0;
`endif
      default:    mfc0_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: cycle table with expectation queue,
// plus a hand-timed vector latency / reset-in-handler sequence.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] cur_pc;
  logic        exc_ill, exc_ovf, exc_sys, irq, eret;
  logic        exc_addr_err;
  logic [31:0] bad_addr;
  logic [1:0]  mfc0_sel;
  logic [31:0] mfc0_data;
  logic        stall, flush, redirect, in_handler;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .cur_pc       (cur_pc),
    .exc_ill      (exc_ill),
    .exc_ovf      (exc_ovf),
    .exc_sys      (exc_sys),
    .irq          (irq),
    .eret         (eret),
`ifdef EXC_BADADDR_EN
    .exc_addr_err (exc_addr_err),
    .bad_addr     (bad_addr),
`endif
    .mfc0_sel     (mfc0_sel),
    .mfc0_data    (mfc0_data),
    .stall        (stall),
    .flush        (flush),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .in_handler   (in_handler)
  );

  typedef struct {
    logic        rst, iv;
    logic [31:0] pc;
    logic        ill, ovf, sys, irq, eret;
    logic [1:0]  sel;
    logic        st, fl, rd;
    logic [31:0] rpc;
    logic        ih;
    logic [31:0] md;
  } vec_t;

  typedef struct {
    int          row;
    logic        st, fl, rd;
    logic [31:0] rpc;
    logic        ih;
    logic [31:0] md;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(
    input logic r, input logic iv, input logic [31:0] pc,
    input logic il, input logic ov, input logic sy,
    input logic iq, input logic er, input logic [1:0] sl,
    input logic st, input logic fl, input logic rd,
    input logic [31:0] rpc, input logic ih,
    input logic [31:0] md
  );
    vec_t t;
    t.rst = r;  t.iv = iv;  t.pc = pc;
    t.ill = il; t.ovf = ov; t.sys = sy;
    t.irq = iq; t.eret = er; t.sel = sl;
    t.st = st;  t.fl = fl;  t.rd = rd;
    t.rpc = rpc; t.ih = ih; t.md = md;
    return t;
  endfunction

  task automatic check(
    input string name, input logic [31:0] act,
    input logic [31:0] req
  );
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; instr_valid = 1'b0; cur_pc = 32'd0;
    exc_ill = 1'b0; exc_ovf = 1'b0; exc_sys = 1'b0;
    irq = 1'b0; eret = 1'b0; mfc0_sel = 2'd0;
    exc_addr_err = 1'b0; bad_addr = 32'd0;
  endtask

  task automatic apply_row(input int idx, input vec_t t);
    exp_t e, g;
    rst = t.rst; instr_valid = t.iv; cur_pc = t.pc;
    exc_ill = t.ill; exc_ovf = t.ovf; exc_sys = t.sys;
    irq = t.irq; eret = t.eret; mfc0_sel = t.sel;
    e.row = idx; e.st = t.st; e.fl = t.fl; e.rd = t.rd;
    e.rpc = t.rpc; e.ih = t.ih; e.md = t.md;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    total++;
    if ({stall, flush, redirect, redirect_pc, in_handler,
         mfc0_data} !== {g.st, g.fl, g.rd, g.rpc, g.ih, g.md})
    begin
      bad++;
      $display("FAIL row%0d: got st=%b fl=%b rd=%b rpc=%h ih=%b md=%h expected st=%b fl=%b rd=%b rpc=%h ih=%b md=%h",
        g.row, stall, flush, redirect, redirect_pc, in_handler,
        mfc0_data, g.st, g.fl, g.rd, g.rpc, g.ih, g.md);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    //         rst iv pc            il ov sy iq er sel st fl rd rpc           ih md
    tbl.push_back(v(1,0,32'h0,       0,0,0,0,0,2'd0, 0,0,0,32'h0,      0,32'h1));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd1, 0,0,0,32'h0,      0,32'h0));
    tbl.push_back(v(0,1,32'h00400010,0,1,0,0,0,2'd2, 0,0,0,32'h0,      0,32'h0));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd0, 1,1,0,32'h0,      0,32'h1));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd2, 0,0,1,32'h180,    0,32'h00400010));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd1, 0,0,0,32'h0,      1,32'h30));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd0, 0,0,0,32'h0,      1,32'h0));
    tbl.push_back(v(0,1,32'h00000200,0,0,0,0,1,2'd0, 0,0,0,32'h0,      1,32'h0));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd2, 0,0,1,32'h00400010,1,32'h00400010));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd0, 0,0,0,32'h0,      0,32'h1));
    tbl.push_back(v(0,1,32'h00000300,0,0,0,0,1,2'd0, 0,0,0,32'h0,      0,32'h1));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd0, 0,0,0,32'h0,      0,32'h1));
    tbl.push_back(v(0,1,32'hFFFFFFFC,0,0,0,1,0,2'd2, 0,0,0,32'h0,      0,32'h00400010));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd2, 1,1,0,32'h0,      0,32'h0));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd1, 0,0,1,32'h180,    0,32'h0));
    tbl.push_back(v(0,1,32'h00000400,0,0,0,1,0,2'd0, 0,0,0,32'h0,      1,32'h0));
    tbl.push_back(v(0,1,32'h00000404,0,0,0,1,0,2'd0, 0,0,0,32'h0,      1,32'h0));
    tbl.push_back(v(0,1,32'h00000408,0,0,0,0,1,2'd2, 0,0,0,32'h0,      1,32'h0));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd0, 0,0,1,32'h0,      1,32'h0));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd0, 0,0,0,32'h0,      0,32'h1));
    tbl.push_back(v(0,1,32'h00001000,1,0,1,1,0,2'd1, 0,0,0,32'h0,      0,32'h0));
    tbl.push_back(v(0,0,32'h0,       0,0,0,1,0,2'd1, 1,1,0,32'h0,      0,32'h28));
    tbl.push_back(v(0,0,32'h0,       0,0,0,1,0,2'd2, 0,0,1,32'h180,    0,32'h1000));
    tbl.push_back(v(0,1,32'h00002000,0,0,0,1,0,2'd1, 0,0,0,32'h0,      1,32'h28));
    tbl.push_back(v(0,0,32'h0,       0,0,0,1,0,2'd0, 0,0,0,32'h0,      1,32'h0));
    tbl.push_back(v(0,1,32'h00003000,0,0,1,0,0,2'd0, 0,0,0,32'h0,      1,32'h0));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd0, 1,1,0,32'h0,      1,32'h2));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd2, 0,0,1,32'h180,    1,32'h1000));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd1, 0,0,0,32'h0,      1,32'h20));
    tbl.push_back(v(0,1,32'h00003004,0,0,0,0,1,2'd0, 0,0,0,32'h0,      1,32'h2));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd0, 0,0,1,32'h1000,   1,32'h2));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd0, 0,0,0,32'h0,      0,32'h3));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd3, 0,0,0,32'h0,      0,32'h0));
    tbl.push_back(v(0,1,32'h00005000,0,1,0,0,0,2'd2, 0,0,0,32'h0,      0,32'h1000));
    tbl.push_back(v(1,0,32'h0,       0,0,0,0,0,2'd2, 1,1,0,32'h0,      0,32'h5000));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd2, 0,0,0,32'h0,      0,32'h0));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd0, 0,0,0,32'h0,      0,32'h1));
    tbl.push_back(v(0,1,32'h00006000,0,0,1,0,1,2'd0, 0,0,0,32'h0,      0,32'h1));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd2, 1,1,0,32'h0,      0,32'h6000));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd1, 0,0,1,32'h180,    0,32'h20));
    tbl.push_back(v(0,0,32'h0,       0,0,0,0,0,2'd0, 0,0,0,32'h0,      1,32'h0));

    for (int i = 0; i < tbl.size(); i++) apply_row(i, tbl[i]);

    // Hand sequence: leave handler via reset, then time a fresh vector.
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_in_handler", {31'd0, in_handler}, 32'd0);
    instr_valid = 1'b1; exc_sys = 1'b1; cur_pc = 32'h7000;
    @(posedge clk); #1;
    instr_valid = 1'b0; exc_sys = 1'b0;
    lat = 1;
    while (!redirect && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("vector_latency", lat, 32'd2);
    check("vector_pc", redirect_pc, 32'h180);
    @(posedge clk); #1;
    check("handler_entry", {31'd0, in_handler}, 32'd1);
    mfc0_sel = 2'd2;
    #1;
    check("sys_epc", mfc0_data, 32'h7000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
